hazard_sequencer: RTL and testbench
===================================

// Module: hazard_sequencer
// PURPOSE
//  Central stall/flush controller for the 5-stage core. Each cycle it picks one hazard cause
//  (D$ miss, branch mispredict, load-use, I$ miss) and drives the stall/flush pair of every
//  pipeline register (IF PC, i2d, d2e, e2m, m2w). It also keeps saturating performance
//  counters and a stall watchdog that flags a hung pipeline.
// PARAMETERS
//  CNT_W    32    width of each performance counter
//  TIMEOUT  1024  consecutive if_stall cycles before hang asserts (>=2)
// PORTS
//  clk              in   1      clock
//  rst              in   1      synchronous reset, active-high
//  ic_miss          in   1      I$ output not valid this cycle
//  dc_miss          in   1      D$ access in MEM not complete this cycle
//  ex_mispredict    in   1      EX branch resolved against its prediction
//  ex_valid         in   1      EX holds a valid instruction
//  ex_is_load       in   1      EX instruction is a load
//  ex_rw_addr       in   5      EX destination register
//  ds_uses_rs       in   1      ID instruction reads rs
//  ds_rs_addr       in   5      ID rs address
//  ds_uses_rt       in   1      ID instruction reads rt
//  ds_rt_addr       in   5      ID rt address
//  if_stall         out  1      hold PC
//  i2d_stall/flush  out  1+1    i2d register control
//  d2e_stall/flush  out  1+1    d2e register control
//  e2m_stall/flush  out  1+1    e2m register control
//  m2w_stall/flush  out  1+1    m2w register control
//  state            out  3      registered cause: RUN=0 DSTALL=1 FLUSH=2 LUSTALL=3 ISTALL=4
//  dstall_cycles    out  CNT_W  cycles with cause DSTALL
//  istall_cycles    out  CNT_W  cycles with cause ISTALL
//  lu_events        out  CNT_W  load-use stall events (entries into LUSTALL)
//  mispred_events   out  CNT_W  cycles with cause FLUSH
//  hang             out  1      sticky watchdog flag
// BEHAVIOUR
//  - Control outputs are combinational from inputs (0-cycle latency); state/counters/hang are
//    registered and update on posedge clk.
//  - load_use = ex_valid & ex_is_load & ex_rw_addr!=0 &
//    ((ds_uses_rs & ds_rs_addr==ex_rw_addr) | (ds_uses_rt & ds_rt_addr==ex_rw_addr)).
//  - cause priority: dc_miss > ex_mispredict > load_use > ic_miss > none. Exactly one applies:
//    DSTALL : if,i2d,d2e,e2m stall=1; m2w_flush=1 (bubble into WB); others 0.
//    FLUSH  : i2d_flush=1, d2e_flush=1; all stalls 0 (ic_miss ignored, fetch redirects).
//    LUSTALL: if_stall=1, i2d_stall=1, d2e_flush=1 (bubble into EX).
//    ISTALL : if_stall=1, i2d_flush=1 (bubble into ID).
//    RUN    : all stall/flush 0.
//  - Invariant: a register's stall and flush are never both 1.
//  - While rst=1: all *_stall=0, all *_flush=1 (regardless of inputs); on the edge: state=RUN,
//    counters=0, hang=0, watchdog count=0. Reset mid-stall abandons it; no pending state kept.
//  - state <= cause each cycle.
//  - dstall_cycles/istall_cycles/mispred_events +1 per cycle of matching cause; lu_events +1
//    when cause==LUSTALL and state!=LUSTALL. All counters saturate at 2^CNT_W-1, no wrap.
//  - Watchdog: run_cnt +1 (saturate at TIMEOUT) each cycle if_stall=1, cleared when if_stall=0.
//    hang <= 1 on the edge where run_cnt==TIMEOUT-1 and if_stall=1, i.e. high after TIMEOUT
//    consecutive stalled cycles; stays 1 until rst, even after stall clears.
//  - Inputs with X while rst=1 must not propagate to any output.
// TESTING
//  1 dc_miss=1 for 3 cycles, ic_miss=1 too -> if..e2m stall=1, m2w_flush=1 each cycle; state=1;
//    dstall_cycles=3, istall_cycles=0.
//  2 ex_valid=ex_is_load=1, ex_rw_addr=8, ds_uses_rt=1, ds_rt_addr=8, 1 cycle -> if/i2d stall,
//    d2e_flush; lu_events=1. Repeat with ex_rw_addr=0 -> RUN, no count.
//  3 ex_mispredict=1 with load_use and ic_miss=1 -> only i2d_flush,d2e_flush=1; mispred_events=1.
//  4 ex_mispredict=1 with dc_miss=1 -> DSTALL outputs; mispred_events unchanged.
//  5 TIMEOUT=8, ic_miss=1 for 8 cycles -> hang=1 after 8th edge, stays 1 after ic_miss=0; 7 cycles
//    then 1 RUN cycle then 7 -> hang=0.
//  6 rst=1 during DSTALL -> all flush=1, stall=0 same cycle; next: state=0, counters=0, hang=0;
//    force counter to max-1, 2 more DSTALL cycles -> holds at 2^CNT_W-1.

Source files
------------

// File: rtl/hazard_sequencer.sv
// Pipeline stall/flush controller: picks one hazard cause per cycle, drives per-register
// stall/flush controls, and keeps saturating perf counters plus a stalled-pipeline watchdog.
module hazard_sequencer #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_ic_miss,
    input  logic             i_dc_miss,
    input  logic             i_ex_mispredict,
    input  logic             i_ex_valid,
    input  logic             i_ex_is_load,
    input  logic [4:0]       i_ex_rw_addr,
    input  logic             i_ds_uses_rs,
    input  logic [4:0]       i_ds_rs_addr,
    input  logic             i_ds_uses_rt,
    input  logic [4:0]       i_ds_rt_addr,
    output logic             o_if_stall,
    output logic             o_i2d_stall,
    output logic             o_i2d_flush,
    output logic             o_d2e_stall,
    output logic             o_d2e_flush,
    output logic             o_e2m_stall,
    output logic             o_e2m_flush,
    output logic             o_m2w_stall,
    output logic             o_m2w_flush,
    output logic [2:0]       o_state,
    output logic [CNT_W-1:0] o_dstall_cycles,
    output logic [CNT_W-1:0] o_istall_cycles,
    output logic [CNT_W-1:0] o_lu_events,
    output logic [CNT_W-1:0] o_mispred_events,
    output logic             o_hang
);

    localparam int unsigned RUN_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_DSTALL  = 3'd1,
        ST_FLUSH   = 3'd2,
        ST_LUSTALL = 3'd3,
        ST_ISTALL  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               w_load_use;
    logic [RUN_W-1:0]   r_run_cnt;

    assign w_load_use = i_ex_valid && i_ex_is_load && (i_ex_rw_addr != 5'd0) &&
                        ((i_ds_uses_rs && (i_ds_rs_addr == i_ex_rw_addr)) ||
                         (i_ds_uses_rt && (i_ds_rt_addr == i_ex_rw_addr)));

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_RUN;
        else     r_state <= w_next_state;
    end

    // Cause selection and control decode; reset forces a full flush independent of inputs.
    always_comb begin
        w_next_state = ST_RUN;
        o_if_stall   = 1'b0;
        o_i2d_stall  = 1'b0;
        o_i2d_flush  = 1'b0;
        o_d2e_stall  = 1'b0;
        o_d2e_flush  = 1'b0;
        o_e2m_stall  = 1'b0;
        o_e2m_flush  = 1'b0;
        o_m2w_stall  = 1'b0;
        o_m2w_flush  = 1'b0;
        if (rst) begin
            o_i2d_flush = 1'b1;
            o_d2e_flush = 1'b1;
            o_e2m_flush = 1'b1;
            o_m2w_flush = 1'b1;
        end else begin
            if (i_dc_miss)            w_next_state = ST_DSTALL;
            else if (i_ex_mispredict) w_next_state = ST_FLUSH;
            else if (w_load_use)      w_next_state = ST_LUSTALL;
            else if (i_ic_miss)       w_next_state = ST_ISTALL;
            case (w_next_state)
                ST_DSTALL: begin
                    o_if_stall  = 1'b1;
                    o_i2d_stall = 1'b1;
                    o_d2e_stall = 1'b1;
                    o_e2m_stall = 1'b1;
                    o_m2w_flush = 1'b1;
                end
                ST_FLUSH: begin
                    o_i2d_flush = 1'b1;
                    o_d2e_flush = 1'b1;
                end
                ST_LUSTALL: begin
                    o_if_stall  = 1'b1;
                    o_i2d_stall = 1'b1;
                    o_d2e_flush = 1'b1;
                end
                ST_ISTALL: begin
                    o_if_stall  = 1'b1;
                    o_i2d_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_state = r_state;

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_dstall_cycles  <= '0;
            o_istall_cycles  <= '0;
            o_lu_events      <= '0;
            o_mispred_events <= '0;
        end else begin
            if (w_next_state == ST_DSTALL && o_dstall_cycles != '1)
                o_dstall_cycles <= o_dstall_cycles + CNT_W'(1);
            if (w_next_state == ST_ISTALL && o_istall_cycles != '1)
                o_istall_cycles <= o_istall_cycles + CNT_W'(1);
            if (w_next_state == ST_FLUSH && o_mispred_events != '1)
                o_mispred_events <= o_mispred_events + CNT_W'(1);
            if (w_next_state == ST_LUSTALL && r_state != ST_LUSTALL && o_lu_events != '1)
                o_lu_events <= o_lu_events + CNT_W'(1);
        end
    end

    // Watchdog: hang latches after TIMEOUT consecutive fetch-stall cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_run_cnt <= '0;
            o_hang    <= 1'b0;
        end else if (o_if_stall) begin
            if (r_run_cnt != RUN_W'(TIMEOUT))
                r_run_cnt <= r_run_cnt + RUN_W'(1);
            if (r_run_cnt == RUN_W'(TIMEOUT - 1))
                o_hang <= 1'b1;
        end else begin
            r_run_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Scoreboarded random + directed bench for hazard_sequencer against a cause-level reference model.
module tb_hazard_sequencer;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned TIMEOUT = 8;
    localparam int          CMAX    = 15;

    typedef struct packed {
        logic       rst, ic, dc, mp, exv, exl;
        logic [4:0] exa;
        logic       urs;
        logic [4:0] rsa;
        logic       urt;
        logic [4:0] rta;
    } in_t;

    typedef struct {
        logic [8:0] ctrl;
        int         state, dst, ist, lu, mp;
        bit         hang;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    in_t cur, prv;
    logic o_if_stall, o_i2d_stall, o_i2d_flush, o_d2e_stall, o_d2e_flush;
    logic o_e2m_stall, o_e2m_flush, o_m2w_stall, o_m2w_flush, o_hang;
    logic [2:0] o_state;
    logic [CNT_W-1:0] o_dst, o_ist, o_lu, o_mp;

    hazard_sequencer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(cur.rst),
        .i_ic_miss(cur.ic), .i_dc_miss(cur.dc), .i_ex_mispredict(cur.mp),
        .i_ex_valid(cur.exv), .i_ex_is_load(cur.exl), .i_ex_rw_addr(cur.exa),
        .i_ds_uses_rs(cur.urs), .i_ds_rs_addr(cur.rsa),
        .i_ds_uses_rt(cur.urt), .i_ds_rt_addr(cur.rta),
        .o_if_stall(o_if_stall), .o_i2d_stall(o_i2d_stall), .o_i2d_flush(o_i2d_flush),
        .o_d2e_stall(o_d2e_stall), .o_d2e_flush(o_d2e_flush),
        .o_e2m_stall(o_e2m_stall), .o_e2m_flush(o_e2m_flush),
        .o_m2w_stall(o_m2w_stall), .o_m2w_flush(o_m2w_flush),
        .o_state(o_state), .o_dstall_cycles(o_dst), .o_istall_cycles(o_ist),
        .o_lu_events(o_lu), .o_mispred_events(o_mp), .o_hang(o_hang)
    );

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state (values after the most recent edge).
    int m_state, m_dst, m_ist, m_lu, m_mp, m_consec;
    bit m_hang;

    function automatic int cause_of(in_t v);
        bit lu;
        lu = v.exv && v.exl && v.exa != 0 &&
             ((v.urs && v.rsa == v.exa) || (v.urt && v.rta == v.exa));
        if (v.dc) return 1;
        if (v.mp) return 2;
        if (lu)   return 3;
        if (v.ic) return 4;
        return 0;
    endfunction

    // Bit order: if_s, i2d_s, i2d_f, d2e_s, d2e_f, e2m_s, e2m_f, m2w_s, m2w_f
    function automatic logic [8:0] ctrl_of(in_t v);
        if (v.rst) return 9'b0_01_01_01_01;
        case (cause_of(v))
            1:       return 9'b1_10_10_10_01;
            2:       return 9'b0_01_01_00_00;
            3:       return 9'b1_10_01_00_00;
            4:       return 9'b1_01_00_00_00;
            default: return 9'b0_00_00_00_00;
        endcase
    endfunction

    function automatic int sat_inc(int x);
        return (x >= CMAX) ? CMAX : x + 1;
    endfunction

    task automatic model_edge(in_t p);
        int c;
        logic [8:0] cv;
        if (p.rst) begin
            m_state = 0; m_dst = 0; m_ist = 0; m_lu = 0; m_mp = 0;
            m_consec = 0; m_hang = 0;
            return;
        end
        c  = cause_of(p);
        cv = ctrl_of(p);
        if (c == 1) m_dst = sat_inc(m_dst);
        if (c == 4) m_ist = sat_inc(m_ist);
        if (c == 2) m_mp  = sat_inc(m_mp);
        if (c == 3 && m_state != 3) m_lu = sat_inc(m_lu);
        m_state = c;
        if (cv[8]) m_consec++;
        else       m_consec = 0;
        if (m_consec >= int'(TIMEOUT)) m_hang = 1;
    endtask

    task automatic apply(in_t v);
        exp_t e;
        @(posedge clk);
        #1;
        model_edge(prv);
        cur = v;
        prv = v;
        e.ctrl = ctrl_of(v);
        e.state = m_state; e.dst = m_dst; e.ist = m_ist; e.lu = m_lu; e.mp = m_mp;
        e.hang = m_hang;
        exp_q.push_back(e);
    endtask

    function automatic in_t idle();
        in_t v;
        v = '0;
        return v;
    endfunction

    function automatic in_t rst_in();
        in_t v;
        v = 'x;
        v.rst = 1'b1;
        return v;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every presented cycle against the scoreboard.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ctrl", int'({o_if_stall, o_i2d_stall, o_i2d_flush, o_d2e_stall, o_d2e_flush,
                              o_e2m_stall, o_e2m_flush, o_m2w_stall, o_m2w_flush}), int'(e.ctrl));
            chk("state", int'(o_state), e.state);
            chk("dstall_cycles", int'(o_dst), e.dst);
            chk("istall_cycles", int'(o_ist), e.ist);
            chk("lu_events", int'(o_lu), e.lu);
            chk("mispred_events", int'(o_mp), e.mp);
            chk("hang", int'(o_hang), int'(e.hang));
        end
    end

    initial begin
        in_t v;
        int  wait_cnt;
        cur = rst_in();
        prv = rst_in();
        m_state = 0; m_dst = 0; m_ist = 0; m_lu = 0; m_mp = 0; m_consec = 0; m_hang = 0;
        repeat (2) apply(rst_in());

        // D$ miss with I$ miss for 3 cycles
        v = idle(); v.dc = 1; v.ic = 1;
        repeat (3) apply(v);
        apply(idle());

        // Load-use on rt, then same with x0 destination
        v = idle(); v.exv = 1; v.exl = 1; v.exa = 5'd8; v.urt = 1; v.rta = 5'd8;
        apply(v);
        apply(idle());
        v.exa = 5'd0; v.rta = 5'd0;
        apply(v);
        apply(idle());

        // Mispredict beats load-use and I$ miss; D$ miss beats mispredict
        v = idle(); v.mp = 1; v.ic = 1; v.exv = 1; v.exl = 1; v.exa = 5'd3;
        v.urs = 1; v.rsa = 5'd3;
        apply(v);
        v = idle(); v.mp = 1; v.dc = 1;
        apply(v);
        apply(idle());

        // Watchdog: 8 stalled cycles hang, then sticky after stall clears
        v = idle(); v.ic = 1;
        repeat (TIMEOUT) apply(v);
        repeat (3) apply(idle());
        apply(rst_in());
        repeat (TIMEOUT - 1) apply(v);
        apply(idle());
        repeat (TIMEOUT - 1) apply(v);
        apply(idle());

        // Reset in the middle of a D$ stall, then drive the counter into saturation
        v = idle(); v.dc = 1;
        repeat (2) apply(v);
        apply(rst_in());
        repeat (CMAX + 3) apply(v);
        apply(idle());

        // Randomized traffic with occasional reset
        repeat (3000) begin
            v = idle();
            v.rst = ($urandom_range(0, 199) == 0);
            v.dc  = ($urandom_range(0, 7) == 0);
            v.mp  = ($urandom_range(0, 9) == 0);
            v.ic  = ($urandom_range(0, 2) == 0);
            v.exv = 1'($urandom);
            v.exl = 1'($urandom);
            v.exa = 5'($urandom_range(0, 3));
            v.urs = 1'($urandom);
            v.rsa = 5'($urandom_range(0, 3));
            v.urt = 1'($urandom);
            v.rta = 5'($urandom_range(0, 3));
            if (v.rst) v = rst_in();
            apply(v);
        end
        apply(idle());

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(negedge clk);
            #1;
            wait_cnt++;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
